// File: rtl/sum_pipe_collect.sv
// sum_pipe_collect
//   Collection stage behind the pipelined 4-bit adder. Qualified (idx, sum)
//   results are captured into a small first-word-fall-through FIFO. The FIFO
//   head is presented to the consumer with a valid/ready handshake. The block
//   also keeps a wrapping running total of accepted sums and checks that
//   result indices arrive in consecutive order. The adder cannot be stalled,
//   so any result arriving while the FIFO is full and not draining is dropped
//   and flagged.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   ACC_W  running-total width
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   valid_in    idx_in/sum_in qualifier
//   idx_in      result index from the adder
//   sum_in      4-bit sum from the adder
//   clear_acc   synchronous clear of the running total
//   out_ready   consumer accepts the head entry
//   out_valid   head entry present
//   idx_out     head index (0 when empty)
//   sum_out     head sum (0 when empty)
//   fifo_count  occupied entries, 0..DEPTH
//   full        fifo_count == DEPTH
//   empty       fifo_count == 0
//   acc_total   running total of accepted sums, wraps modulo 2^ACC_W
//   overflow    sticky: an input was dropped
//   seq_error   sticky: an out-of-order index was seen
module sum_pipe_collect #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ACC_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     valid_in,
   input  logic [3:0]               idx_in,
   input  logic [3:0]               sum_in,
   input  logic                     clear_acc,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [3:0]               idx_out,
   output logic [3:0]               sum_out,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     full,
   output logic                     empty,
   output logic [ACC_W-1:0]         acc_total,
   output logic                     overflow,
   output logic                     seq_error
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [3:0]    exp_idx;
   logic [7:0]    head;
   logic          pop;
   logic          push;

   assign empty      = (count == '0);
   assign full       = (count == CW'(DEPTH));
   assign out_valid  = !empty;
   assign fifo_count = count;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      pop  = out_valid && out_ready;
      push = valid_in && (!full || pop);
   end

   always_comb begin
      head    = mem[rd_ptr];
      idx_out = out_valid ? head[7:4] : '0;
      sum_out = out_valid ? head[3:0] : '0;
   end

   // FIFO storage, pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {idx_in, sum_in};
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Running total, sticky flags and index sequence tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_total <= '0;
         overflow  <= 1'b0;
         seq_error <= 1'b0;
         exp_idx   <= '0;
      end else begin
         if (clear_acc) begin
            acc_total <= push ? ACC_W'(sum_in) : '0;
         end else if (push) begin
            acc_total <= acc_total + ACC_W'(sum_in);
         end

         // valid_in without push is exactly the full-and-not-draining drop
         if (valid_in && !push) begin
            overflow <= 1'b1;
         end

         // dropped inputs still take part in the order check
         if (valid_in) begin
            if (idx_in != exp_idx) begin
               seq_error <= 1'b1;
            end
            exp_idx <= idx_in + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_sum_pipe_collect.sv
module tb_sum_pipe_collect;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned ACC_W = 8;

   logic       clk;
   logic       reset;
   logic       valid_in;
   logic [3:0] idx_in;
   logic [3:0] sum_in;
   logic       clear_acc;
   logic       out_ready;
   logic       out_valid;
   logic [3:0] idx_out;
   logic [3:0] sum_out;
   logic [2:0] fifo_count;
   logic       full;
   logic       empty;
   logic [7:0] acc_total;
   logic       overflow;
   logic       seq_error;

   int n_checks;
   int n_pass;

   // reference model state
   logic [7:0] m_q[$];
   int         m_acc;
   logic       m_ovf;
   logic       m_seq;
   logic [3:0] m_exp;

   sum_pipe_collect #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .idx_in     (idx_in),
      .sum_in     (sum_in),
      .clear_acc  (clear_acc),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .idx_out    (idx_out),
      .sum_out    (sum_out),
      .fifo_count (fifo_count),
      .full       (full),
      .empty      (empty),
      .acc_total  (acc_total),
      .overflow   (overflow),
      .seq_error  (seq_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_q.delete();
      m_acc = 0;
      m_ovf = 1'b0;
      m_seq = 1'b0;
      m_exp = 4'd0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset     = 1'b1;
      valid_in  = 1'b0;
      idx_in    = 4'd0;
      sum_in    = 4'd0;
      clear_acc = 1'b0;
      out_ready = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // one clock of stimulus; model follows the queue-level rules
   task automatic step(input logic v, input logic [3:0] i, input logic [3:0] s,
                       input logic clr, input logic rdy);
      logic pop;
      logic push;
      valid_in  = v;
      idx_in    = i;
      sum_in    = s;
      clear_acc = clr;
      out_ready = rdy;
      pop  = (m_q.size() != 0) && rdy;
      push = v && ((m_q.size() < DEPTH) || pop);
      @(posedge clk);
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({i, s});
      if (v && !push) m_ovf = 1'b1;
      if (v) begin
         if (i != m_exp) m_seq = 1'b1;
         m_exp = i + 4'd1;
      end
      if (clr) m_acc = push ? int'(s) : 0;
      else if (push) m_acc = (m_acc + int'(s)) % (1 << ACC_W);
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", fifo_count); else n_pass++;
      n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else n_pass++;
      n_checks++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else n_pass++;
      n_checks++; if ({idx_out, sum_out} !== 8'h00) $display("FAIL reset_head got=%h exp=00", {idx_out, sum_out}); else n_pass++;
      n_checks++; if (acc_total !== 8'd0) $display("FAIL reset_acc got=%0d exp=0", acc_total); else n_pass++;
      n_checks++; if ({overflow, seq_error} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {overflow, seq_error}); else n_pass++;
   endtask

   task automatic test_fill();
      apply_reset();
      for (int k = 0; k < 4; k++) step(1'b1, 4'(k), 4'(k + 1), 1'b0, 1'b0);
      n_checks++; if (full !== 1'b1) $display("FAIL fill_full got=%b exp=1", full); else n_pass++;
      n_checks++; if (fifo_count !== 3'd4) $display("FAIL fill_count got=%0d exp=4", fifo_count); else n_pass++;
      n_checks++; if (acc_total !== 8'd10) $display("FAIL fill_acc got=%0d exp=10", acc_total); else n_pass++;
      n_checks++; if ({idx_out, sum_out} !== 8'h01) $display("FAIL fill_head got=%h exp=01", {idx_out, sum_out}); else n_pass++;
      n_checks++; if ({overflow, seq_error} !== 2'b00) $display("FAIL fill_flags got=%b exp=00", {overflow, seq_error}); else n_pass++;
   endtask

   // continues from the full state left by test_fill
   task automatic test_drop_drain();
      step(1'b1, 4'd4, 4'd5, 1'b0, 1'b0);
      n_checks++; if (overflow !== 1'b1) $display("FAIL drop_ovf got=%b exp=1", overflow); else n_pass++;
      n_checks++; if (acc_total !== 8'd10) $display("FAIL drop_acc got=%0d exp=10", acc_total); else n_pass++;
      n_checks++; if (fifo_count !== 3'd4) $display("FAIL drop_count got=%0d exp=4", fifo_count); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (sum_out !== 4'(k + 1)) $display("FAIL drain_sum%0d got=%0d exp=%0d", k, sum_out, k + 1); else n_pass++;
         step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
      end
      n_checks++; if (empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", empty); else n_pass++;
      n_checks++; if ({idx_out, sum_out} !== 8'h00) $display("FAIL drain_head got=%h exp=00", {idx_out, sum_out}); else n_pass++;
   endtask

   task automatic test_full_pop();
      logic [7:0] exp_head;
      apply_reset();
      for (int k = 0; k < 4; k++) step(1'b1, 4'(k), 4'(k + 1), 1'b0, 1'b0);
      step(1'b1, 4'd4, 4'd5, 1'b0, 1'b1);
      n_checks++; if (fifo_count !== 3'd4) $display("FAIL fullpop_count got=%0d exp=4", fifo_count); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf got=%b exp=0", overflow); else n_pass++;
      n_checks++; if (acc_total !== 8'd15) $display("FAIL fullpop_acc got=%0d exp=15", acc_total); else n_pass++;
      for (int k = 1; k < 5; k++) begin
         exp_head = {4'(k), 4'(k + 1)};
         n_checks++;
         if ({idx_out, sum_out} !== exp_head) $display("FAIL fullpop_head%0d got=%h exp=%h", k, {idx_out, sum_out}, exp_head); else n_pass++;
         step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
      end
      n_checks++; if (empty !== 1'b1) $display("FAIL fullpop_empty got=%b exp=1", empty); else n_pass++;
   endtask

   task automatic test_seq();
      apply_reset();
      step(1'b1, 4'd0, 4'd1, 1'b0, 1'b1);
      step(1'b1, 4'd1, 4'd1, 1'b0, 1'b1);
      n_checks++; if (seq_error !== 1'b0) $display("FAIL seq_inorder got=%b exp=0", seq_error); else n_pass++;
      step(1'b1, 4'd3, 4'd1, 1'b0, 1'b1);
      n_checks++; if (seq_error !== 1'b1) $display("FAIL seq_skip got=%b exp=1", seq_error); else n_pass++;
      step(1'b1, 4'd4, 4'd1, 1'b0, 1'b1);
      n_checks++; if (seq_error !== 1'b1) $display("FAIL seq_sticky got=%b exp=1", seq_error); else n_pass++;
      n_checks++; if (fifo_count !== 3'd1) $display("FAIL seq_count got=%0d exp=1", fifo_count); else n_pass++;
   endtask

   task automatic test_acc_wrap();
      apply_reset();
      for (int k = 0; k < 18; k++) step(1'b1, 4'(k), 4'd15, 1'b0, 1'b1);
      n_checks++; if (acc_total !== 8'd14) $display("FAIL wrap_acc got=%0d exp=14", acc_total); else n_pass++;
      n_checks++; if ({overflow, seq_error} !== 2'b00) $display("FAIL wrap_flags got=%b exp=00", {overflow, seq_error}); else n_pass++;
   endtask

   // continues from test_acc_wrap (next index is 2)
   task automatic test_clear();
      step(1'b1, 4'd2, 4'd7, 1'b1, 1'b1);
      n_checks++; if (acc_total !== 8'd7) $display("FAIL clear_push_acc got=%0d exp=7", acc_total); else n_pass++;
      n_checks++; if (fifo_count !== 3'd1) $display("FAIL clear_push_count got=%0d exp=1", fifo_count); else n_pass++;
      step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
      n_checks++; if (acc_total !== 8'd0) $display("FAIL clear_alone_acc got=%0d exp=0", acc_total); else n_pass++;
      n_checks++; if (sum_out !== 4'd7) $display("FAIL clear_alone_head got=%0d exp=7", sum_out); else n_pass++;
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int k = 0; k < 3; k++) step(1'b1, 4'(k), 4'(k + 9), 1'b0, 1'b0);
      valid_in = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (fifo_count !== 3'd0) $display("FAIL async_count got=%0d exp=0", fifo_count); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL async_valid got=%b exp=0", out_valid); else n_pass++;
      n_checks++; if ({idx_out, sum_out} !== 8'h00) $display("FAIL async_head got=%h exp=00", {idx_out, sum_out}); else n_pass++;
      n_checks++; if (acc_total !== 8'd0) $display("FAIL async_acc got=%0d exp=0", acc_total); else n_pass++;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
      step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL async_release_valid got=%b exp=0", out_valid); else n_pass++;
      step(1'b1, 4'd0, 4'd6, 1'b0, 1'b0);
      n_checks++; if ({out_valid, idx_out, sum_out} !== 9'h106) $display("FAIL async_newpush got=%h exp=106", {out_valid, idx_out, sum_out}); else n_pass++;
      n_checks++; if (seq_error !== 1'b0) $display("FAIL async_seq got=%b exp=0", seq_error); else n_pass++;
   endtask

   task automatic test_random();
      logic [3:0] ri;
      logic [7:0] exp_head;
      int         errs;
      apply_reset();
      errs = 0;
      for (int c = 0; c < 400; c++) begin
         ri = ($urandom_range(0, 19) == 0) ? 4'($urandom) : m_exp;
         step($urandom_range(0, 3) != 0, ri, 4'($urandom), $urandom_range(0, 15) == 0,
              $urandom_range(0, 2) == 0);
         exp_head = (m_q.size() != 0) ? m_q[0] : 8'h00;
         n_checks++;
         if (fifo_count !== 3'(m_q.size()) || full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0)
             || out_valid !== (m_q.size() != 0)) begin
            if (errs < 10) $display("FAIL rand_occ cyc=%0d got=%0d/%b/%b/%b exp=%0d", c, fifo_count, full, empty, out_valid, m_q.size());
            errs++;
         end else n_pass++;
         n_checks++;
         if ({idx_out, sum_out} !== exp_head) begin
            if (errs < 10) $display("FAIL rand_head cyc=%0d got=%h exp=%h", c, {idx_out, sum_out}, exp_head);
            errs++;
         end else n_pass++;
         n_checks++;
         if (acc_total !== 8'(m_acc) || overflow !== m_ovf || seq_error !== m_seq) begin
            if (errs < 10) $display("FAIL rand_acc_flags cyc=%0d got=%0d/%b/%b exp=%0d/%b/%b", c, acc_total, overflow, seq_error, m_acc, m_ovf, m_seq);
            errs++;
         end else n_pass++;
      end
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      reset     = 1'b1;
      valid_in  = 1'b0;
      idx_in    = 4'd0;
      sum_in    = 4'd0;
      clear_acc = 1'b0;
      out_ready = 1'b0;
      model_reset();
      test_reset();
      test_fill();
      test_drop_drain();
      test_full_pop();
      test_seq();
      test_acc_wrap();
      test_clear();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
